// File: rtl/circ_buf_ptr_ctrl_if.sv
// Handshake bundle between the circular-buffer pointer controller and the
// producer/consumer datapaths. The master side issues push/pop/flush
// requests. The slave side is the controller, which answers with
// readiness, pointers and occupancy.
interface circ_buf_ptr_ctrl_if #(
  parameter int COLUMNS   = 32,
  parameter int PAR_READ  = 4,
  parameter int PAR_WRITE = 4
);
  localparam int PTR_W = $clog2(COLUMNS);
  localparam int CNT_W = $clog2(COLUMNS + 1);
  localparam int RN_W  = $clog2(PAR_READ + 1);
  localparam int WN_W  = $clog2(PAR_WRITE + 1);

  logic             flush;
  logic             wr_en;
  logic [WN_W-1:0]  wr_num;
  logic             wr_ready;
  logic             rd_en;
  logic [RN_W-1:0]  rd_num;
  logic             rd_ready;
  logic [PTR_W-1:0] write_ptr_out;
  logic [PTR_W-1:0] read_ptr_out;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             req_err;

  modport master (
    output flush, wr_en, wr_num, rd_en, rd_num,
    input  wr_ready, rd_ready, write_ptr_out, read_ptr_out,
           count, full, empty, req_err
  );

  modport slave (
    input  flush, wr_en, wr_num, rd_en, rd_num,
    output wr_ready, rd_ready, write_ptr_out, read_ptr_out,
           count, full, empty, req_err
  );
endinterface

// File: rtl/circ_buf_ptr_ctrl.sv
// Read/write base-pointer controller for a circular column buffer of
// COLUMNS entries. Each cycle it accepts a variable-size push (up to
// PAR_WRITE) and a variable-size pop (up to PAR_READ). It tracks occupancy
// and flags oversized requests. Readiness looks only at the registered
// count, so a same-cycle push never enables a pop and a same-cycle pop
// never frees space for a push.
module circ_buf_ptr_ctrl #(
  parameter int COLUMNS   = 32,
  parameter int PAR_READ  = 4,
  parameter int PAR_WRITE = 4
) (
  input logic                 clk,
  input logic                 rst,
  circ_buf_ptr_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(COLUMNS);
  localparam int CNT_W = $clog2(COLUMNS + 1);
  localparam int RN_W  = $clog2(PAR_READ + 1);
  localparam int WN_W  = $clog2(PAR_WRITE + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COLUMNS);
  // Limits are held one bit wider than the request fields. The legality
  // compare then stays meaningful even when the field cannot exceed the limit.
  localparam logic [WN_W:0]    WN_MAX  = (WN_W + 1)'(PAR_WRITE);
  localparam logic [RN_W:0]    RN_MAX  = (RN_W + 1)'(PAR_READ);
  localparam logic [PTR_W:0]   PTR_WRAP = (PTR_W + 1)'(COLUMNS);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic             wr_legal, rd_legal;
  logic             wr_fit, rd_fit;
  logic             wr_rdy, rd_rdy;
  logic [WN_W-1:0]  w_acc;
  logic [RN_W-1:0]  r_acc;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   cnt_sum;
  logic             err_nxt;

  // Advance a pointer by acc entries with one conditional wrap. acc never
  // exceeds COLUMNS, so a single subtraction keeps the result in range.
  function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W:0]   acc);
    logic [PTR_W:0] sum;
    sum = {1'b0, p} + acc;
    if (sum >= PTR_WRAP)
      sum = sum - PTR_WRAP;
    return sum[PTR_W-1:0];
  endfunction

  // Request legality, readiness and the amounts actually accepted this cycle
  always_comb begin
    wr_legal = {1'b0, bus.wr_num} <= WN_MAX;
    rd_legal = {1'b0, bus.rd_num} <= RN_MAX;
    wr_fit   = (CNT_MAX - cnt_q) >= CNT_W'(bus.wr_num);
    rd_fit   = cnt_q >= CNT_W'(bus.rd_num);
    wr_rdy   = wr_legal && wr_fit;
    rd_rdy   = rd_legal && rd_fit;
    w_acc    = (bus.wr_en && wr_rdy) ? bus.wr_num : '0;
    r_acc    = (bus.rd_en && rd_rdy) ? bus.rd_num : '0;
    err_nxt  = (bus.wr_en && !wr_legal) || (bus.rd_en && !rd_legal);
  end

  // Next pointers and occupancy; a flush overrides any accepted traffic
  always_comb begin
    wr_ptr_nxt = ptr_adv(wr_ptr_q, (PTR_W + 1)'(w_acc));
    rd_ptr_nxt = ptr_adv(rd_ptr_q, (PTR_W + 1)'(r_acc));
    cnt_sum    = {1'b0, cnt_q} + (CNT_W + 1)'(w_acc) - (CNT_W + 1)'(r_acc);
    cnt_nxt    = cnt_sum[CNT_W-1:0];
    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      cnt_nxt    = '0;
    end
  end

  // State registers. The error pulse is always taken from this cycle's
  // requests, including flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      cnt_q    <= cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  assign bus.wr_ready      = wr_rdy;
  assign bus.rd_ready      = rd_rdy;
  assign bus.write_ptr_out = wr_ptr_q;
  assign bus.read_ptr_out  = rd_ptr_q;
  assign bus.count         = cnt_q;
  assign bus.full          = (cnt_q == CNT_MAX);
  assign bus.empty         = (cnt_q == '0);
  assign bus.req_err       = err_q;
endmodule

// File: tb/tb_circ_buf_ptr_ctrl.sv
// Bench for circ_buf_ptr_ctrl. The main instance uses a 12-deep buffer
// with pops of up to 4 and pushes of up to 3. It runs directed scenarios
// and random traffic against a modular-arithmetic occupancy model. A second
// instance with default parameters covers full-buffer pointer wrap.
module tb_circ_buf_ptr_ctrl;
  localparam int C    = 12;
  localparam int PR   = 4;
  localparam int PW   = 3;
  localparam int RN_W = $clog2(PR + 1);
  localparam int WN_W = $clog2(PW + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  circ_buf_ptr_ctrl_if #(.COLUMNS(C), .PAR_READ(PR), .PAR_WRITE(PW)) bif ();
  circ_buf_ptr_ctrl #(.COLUMNS(C), .PAR_READ(PR), .PAR_WRITE(PW)) dut (
    .clk(clk), .rst(rst), .bus(bif));

  circ_buf_ptr_ctrl_if bif2 ();
  circ_buf_ptr_ctrl dut2 (.clk(clk), .rst(rst), .bus(bif2));

  int m_cnt, m_wp, m_rp;
  bit m_err;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_wr_ok(int wn);
    return (wn <= PW) && ((C - m_cnt) >= wn);
  endfunction

  function automatic bit m_rd_ok(int rn);
    return (rn <= PR) && (m_cnt >= rn);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_err = 1'b0;
  endtask

  // Apply the request sitting on the interface at this clock edge to the model
  task automatic model_edge();
    int wn, rn, wa, ra;
    bit ill;
    wn  = int'(bif.wr_num);
    rn  = int'(bif.rd_num);
    ill = (bif.wr_en && wn > PW) || (bif.rd_en && rn > PR);
    wa  = (bif.wr_en && m_wr_ok(wn)) ? wn : 0;
    ra  = (bif.rd_en && m_rd_ok(rn)) ? rn : 0;
    if (bif.flush) begin
      m_cnt = 0; m_wp = 0; m_rp = 0;
    end else begin
      m_wp  = (m_wp + wa) % C;
      m_rp  = (m_rp + ra) % C;
      m_cnt = m_cnt + wa - ra;
    end
    m_err = ill;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic fl, input logic we, input logic [WN_W-1:0] wn,
                       input logic re, input logic [RN_W-1:0] rn);
    bif.flush = fl; bif.wr_en = we; bif.wr_num = wn; bif.rd_en = re; bif.rd_num = rn;
  endtask

  task automatic cyc(input logic fl, input logic we, input logic [WN_W-1:0] wn,
                     input logic re, input logic [RN_W-1:0] rn);
    drive(fl, we, wn, re, rn);
    tick();
  endtask

  // Compare every DUT output against the model once per cycle
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("count", 32'(bif.count), m_cnt);
      chk("write_ptr", 32'(bif.write_ptr_out), m_wp);
      chk("read_ptr", 32'(bif.read_ptr_out), m_rp);
      chk("full", 32'(bif.full), 32'(m_cnt == C));
      chk("empty", 32'(bif.empty), 32'(m_cnt == 0));
      chk("req_err", 32'(bif.req_err), 32'(m_err));
      chk("wr_ready", 32'(bif.wr_ready), 32'(m_wr_ok(int'(bif.wr_num))));
      chk("rd_ready", 32'(bif.rd_ready), 32'(m_rd_ok(int'(bif.rd_num))));
      chk("ptr_invariant",
          32'((int'(bif.write_ptr_out) - int'(bif.read_ptr_out) + C) % C),
          32'(int'(bif.count) % C));
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    bif2.flush = 0; bif2.wr_en = 0; bif2.wr_num = '0; bif2.rd_en = 0; bif2.rd_num = '0;
    model_reset();
    #2;
    chk("rst_count", 32'(bif.count), 0);
    chk("rst_empty", 32'(bif.empty), 1);
    chk("rst_full", 32'(bif.full), 0);
    #10 rst = 1'b0;
    tick();
    chk_en = 1'b1;

    // fill to full, then a further push is refused
    repeat (4) cyc(0, 1, 3, 0, 0);
    chk("fill_count", 32'(bif.count), 12);
    chk("fill_full", 32'(bif.full), 1);
    chk("fill_wp", 32'(bif.write_ptr_out), 0);
    drive(0, 1, 1, 0, 0);
    #1 chk("full_wr_ready", 32'(bif.wr_ready), 0);
    tick();
    chk("full_hold", 32'(bif.count), 12);

    // walk read pointer to 10 with count 6, then pop across the wrap
    cyc(0, 0, 0, 1, 4);
    cyc(0, 0, 0, 1, 4);
    cyc(0, 0, 0, 1, 2);
    cyc(0, 1, 3, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("pre_wrap_rp", 32'(bif.read_ptr_out), 10);
    chk("pre_wrap_cnt", 32'(bif.count), 6);
    cyc(0, 0, 0, 1, 4);
    chk("wrap_rp", 32'(bif.read_ptr_out), 2);
    chk("wrap_cnt", 32'(bif.count), 2);
    drive(0, 0, 0, 1, 4);
    #1 chk("short_rd_ready", 32'(bif.rd_ready), 0);
    tick();
    chk("short_hold", 32'(bif.count), 2);
    cyc(0, 0, 0, 1, 2);
    chk("drain_empty", 32'(bif.empty), 1);
    chk("drain_rp", 32'(bif.read_ptr_out), 4);

    // simultaneous push and pop
    cyc(0, 1, 3, 0, 0);
    cyc(0, 1, 2, 0, 0);
    chk("sim_pre_cnt", 32'(bif.count), 5);
    cyc(0, 1, 3, 1, 4);
    chk("sim_cnt", 32'(bif.count), 4);
    chk("sim_wp", 32'(bif.write_ptr_out), 0);
    chk("sim_rp", 32'(bif.read_ptr_out), 8);
    cyc(0, 0, 0, 1, 1);
    drive(0, 1, 3, 1, 4);
    #1;
    chk("sim3_rd_ready", 32'(bif.rd_ready), 0);
    chk("sim3_wr_ready", 32'(bif.wr_ready), 1);
    tick();
    chk("sim3_cnt", 32'(bif.count), 6);
    chk("sim3_wp", 32'(bif.write_ptr_out), 3);
    chk("sim3_rp", 32'(bif.read_ptr_out), 9);

    // oversized pop pulses req_err for one cycle; a zero pop is harmless
    drive(0, 0, 0, 1, 5);
    #1 chk("ill_rd_ready", 32'(bif.rd_ready), 0);
    tick();
    chk("ill_err", 32'(bif.req_err), 1);
    chk("ill_cnt", 32'(bif.count), 6);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("ill_err_clear", 32'(bif.req_err), 0);
    drive(0, 0, 0, 1, 0);
    #1 chk("zero_rd_ready", 32'(bif.rd_ready), 1);
    tick();
    chk("zero_cnt", 32'(bif.count), 6);
    chk("zero_err", 32'(bif.req_err), 0);

    // flush wins over same-cycle push and pop
    cyc(0, 1, 1, 0, 0);
    chk("pre_flush_cnt", 32'(bif.count), 7);
    cyc(1, 1, 3, 1, 2);
    chk("flush_cnt", 32'(bif.count), 0);
    chk("flush_wp", 32'(bif.write_ptr_out), 0);
    chk("flush_rp", 32'(bif.read_ptr_out), 0);
    chk("flush_empty", 32'(bif.empty), 1);

    // random traffic, occasionally illegal pop sizes and flushes
    repeat (800) begin
      cyc(logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 1)),
          WN_W'($urandom_range(0, PW)), logic'($urandom_range(0, 1)),
          RN_W'($urandom_range(0, PR + 1)));
    end

    // asynchronous reset between edges while pushing
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 3, 0, 0);
    drive(0, 1, 3, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_cnt", 32'(bif.count), 0);
    chk("arst_wp", 32'(bif.write_ptr_out), 0);
    chk("arst_empty", 32'(bif.empty), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_cnt", 32'(bif.count), 0);
    chk("arst_hold_wp", 32'(bif.write_ptr_out), 0);
    chk("arst_hold_err", 32'(bif.req_err), 0);
    @(negedge clk);
    #2;
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // default-parameter instance: fill, then 8 pops of 4 wrap read_ptr to 0
    bif2.wr_en = 1'b1; bif2.wr_num = 3'd4;
    repeat (8) tick();
    bif2.wr_en = 1'b0;
    chk("d_full_cnt", 32'(bif2.count), 32);
    chk("d_full", 32'(bif2.full), 1);
    bif2.rd_en = 1'b1; bif2.rd_num = 3'd4;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("d_pop_rp", 32'(bif2.read_ptr_out), 32'((4 * (i + 1)) % 32));
    end
    bif2.rd_en = 1'b0;
    chk("d_end_rp", 32'(bif2.read_ptr_out), 0);
    chk("d_end_empty", 32'(bif2.empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/circ_buf_ptr_ctrl.md
Name: circ_buf_ptr_ctrl

Overview:
- Parametrised read/write pointer controller for a circular column buffer of COLUMNS entries.
- Each cycle, a producer may push a variable count of 0..PAR_WRITE entries and a consumer may pop 0..PAR_READ entries.
- The block tracks occupancy, drives full/empty, and gates each request with a ready handshake.
- It sits between the buffer write datapath and the parallel-read datapath. It supplies both base pointers to the buffer RAM/mux.

Parameters:
- COLUMNS, 32, buffer depth in entries; any value >= 2, not required to be a power of two.
- PAR_READ, 4, maximum entries popped per cycle; 1..COLUMNS.
- PAR_WRITE, 4, maximum entries pushed per cycle; 1..COLUMNS.
- Derived: PTR_W = $clog2(COLUMNS), CNT_W = $clog2(COLUMNS+1), RN_W = $clog2(PAR_READ+1), WN_W = $clog2(PAR_WRITE+1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pointers and count.
- wr_en  in  1  push request.
- wr_num  in  WN_W  entries to push.
- wr_ready  out  1  push of wr_num is acceptable this cycle (combinational).
- rd_en  in  1  pop request.
- rd_num  in  RN_W  entries to pop.
- rd_ready  out  1  pop of rd_num is acceptable this cycle (combinational).
- write_ptr_out  out  PTR_W  index of next entry to write.
- read_ptr_out  out  PTR_W  index of oldest valid entry.
- count  out  CNT_W  current occupancy, 0..COLUMNS.
- full  out  1  count == COLUMNS.
- empty  out  1  count == 0.
- req_err  out  1  one-cycle registered pulse on an illegal request.

Behaviour:
- Reset (async, rst=1): write_ptr_out=0, read_ptr_out=0, count=0, req_err=0. Hence empty=1 and full=0.
  - Reset asserted mid-operation discards all state immediately, without waiting for a clock edge.
- Ready generation uses registered count only; there is no same-cycle bypass.
  - wr_ready = (wr_num <= PAR_WRITE) && (COLUMNS - count >= wr_num).
  - rd_ready = (rd_num <= PAR_READ) && (count >= rd_num).
- Acceptance:
  - w_acc = wr_en && wr_ready ? wr_num : 0.
  - r_acc = rd_en && rd_ready ? rd_num : 0.
  - A rejected request has no effect; the requester holds or changes it freely.
- Simultaneous push/pop: both are applied in the same edge, with count_next = count + w_acc - r_acc.
  - A push does not make the same-cycle pop ready.
  - A pop does not free space for the same-cycle push.
- Pointer update: next = ptr + acc, computed at PTR_W+1 bits.
  - If next >= COLUMNS, subtract COLUMNS; a single subtraction suffices because acc <= COLUMNS.
  - Result is always < COLUMNS.
- Zero-count request (wr_num=0 or rd_num=0): ready=1, no state change, not an error.
- Illegal request (wr_en with wr_num > PAR_WRITE, or rd_en with rd_num > PAR_READ): rejected, and req_err=1 on the following cycle for one cycle.
- Flush:
  - Has priority over push/pop in the same cycle.
  - Next state equals the reset state; any push/pop that cycle is dropped.
  - req_err is still computed from that cycle's requests.
- Latency: pointers/count/full/empty reflect an accepted request one cycle after acceptance.
- Invariant: (write_ptr_out - read_ptr_out) mod COLUMNS == count mod COLUMNS at all times.
  - count distinguishes full from empty when the pointers are equal.

Test Plan (COLUMNS=12, PAR_READ=4, PAR_WRITE=3 unless noted):
- Fill to full: from reset, wr_en=1, wr_num=3 for 4 cycles.
  - Required: count=12, full=1, write_ptr_out=0 (wrapped).
  - Then wr_num=1 gives wr_ready=0 and no change.
- Wrap read: state read_ptr_out=10, count=6; rd_num=4 accepted.
  - Required: read_ptr_out=2, count=2.
  - Next rd_num=4 gives rd_ready=0, no change; rd_num=2 accepted gives empty=1, read_ptr_out=4.
- Simultaneous: count=5; wr_num=3 and rd_num=4 in the same cycle.
  - Required: both accepted, count=4, both pointers advance.
  - At count=3 with rd_num=4 plus wr_num=3: only the write is accepted, count=6.
- Illegal/zero requests: rd_en with rd_num=5 gives rd_ready=0, req_err=1 for exactly one cycle, no state change.
  - rd_en with rd_num=0 gives rd_ready=1, no change, req_err=0.
- Flush priority: count=7 with flush=1, wr_num=3, rd_num=2 in the same cycle.
  - Required: pointers=0, count=0, empty=1 next cycle.
- Async reset mid-stream: assert rst between clock edges while pushing.
  - Required: outputs go to reset values before the next edge and stay there while rst=1.
  - Default parameters (COLUMNS=32, PAR_READ=4): 8 pops of 4 from full returns read_ptr_out to 0.
